remap_pixel_packer: RTL

- Downstream neighbour of the 2-pixel bilinear interpolator.
- Collects its 8-bit interpolated pixel stream, one pixel per valid cycle with no backpressure, into PIXELS_PER_WORD-wide words.
- Buffers the words in a small FIFO and presents them to the frame-buffer write master over a valid/ready handshake.
- Drives an almost-full stall hint back toward the remap address generator.

---
 rtl/remap_pixel_packer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/remap_pixel_packer.sv
// Packs the 8-bit interpolated pixel stream into PIXELS_PER_WORD-wide words, queued in a show-ahead FIFO.
// Optional macro REMAP_PACKER_FLUSH_EN: eof_in on a non-final lane flushes a PAD_VALUE-padded word.
`timescale 1ns/1ps
module remap_pixel_packer #(
  parameter int unsigned PIXELS_PER_WORD = 8,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned STALL_MARGIN    = 2,
  parameter logic [7:0]  PAD_VALUE       = 8'h00
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [7:0]                          pixel_in,
  input  logic                                pixel_in_valid,
  input  logic                                sof_in,
  input  logic                                eof_in,
  output logic [8*PIXELS_PER_WORD-1:0]        word_out,
  output logic                                word_out_last,
  output logic                                word_out_valid,
  input  logic                                word_out_ready,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_level,
  output logic                                almost_full,
  output logic                                overflow
);

  localparam int unsigned WordW = 8 * PIXELS_PER_WORD;
  localparam int unsigned IdxW  = $clog2(PIXELS_PER_WORD);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW  = PtrW + 1;

  localparam logic [IdxW-1:0] LastLane = IdxW'(PIXELS_PER_WORD - 1);
  localparam logic [LvlW-1:0] DepthLvl = LvlW'(FIFO_DEPTH);
  localparam logic [LvlW-1:0] AfLvl    =
      (STALL_MARGIN >= FIFO_DEPTH) ? '0 : LvlW'(FIFO_DEPTH - STALL_MARGIN);

`ifdef REMAP_PACKER_FLUSH_EN
  localparam bit FlushEn = 1'b1;
`else
  localparam bit FlushEn = 1'b0;
`endif

  logic [IdxW-1:0]  pix_idx_q, pix_idx_d;
  logic [WordW-1:0] pack_q, pack_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             overflow_q, overflow_d;

  logic [WordW-1:0] mem_q [FIFO_DEPTH];
  logic             last_mem_q [FIFO_DEPTH];

  logic [IdxW-1:0]  base_idx;
  logic [WordW-1:0] base_pack, assembled, padded, push_word;
  logic             push_req, push_last, pop, accept, drop;

  // Packing: sof restarts the word before the current pixel is placed.
  always_comb begin
    pix_idx_d = pix_idx_q;
    pack_d    = pack_q;
    push_req  = 1'b0;
    push_word = '0;
    push_last = 1'b0;
    base_idx  = sof_in ? '0 : pix_idx_q;
    base_pack = sof_in ? '0 : pack_q;
    assembled = base_pack;
    padded    = base_pack;
    for (int k = 0; k < int'(PIXELS_PER_WORD); k++) begin
      if (IdxW'(k) == base_idx) begin
        assembled[8*k +: 8] = pixel_in;
        padded[8*k +: 8]    = pixel_in;
      end else if (IdxW'(k) > base_idx) begin
        padded[8*k +: 8] = PAD_VALUE;
      end
    end
    if (pixel_in_valid) begin
      if (base_idx == LastLane) begin
        push_req  = 1'b1;
        push_word = assembled;
        push_last = eof_in;
        pix_idx_d = '0;
        pack_d    = '0;
      end else if (eof_in) begin
        pix_idx_d = '0;
        pack_d    = '0;
        if (FlushEn) begin
          push_req  = 1'b1;
          push_word = padded;
          push_last = 1'b1;
        end
      end else begin
        pix_idx_d = base_idx + IdxW'(1);
        pack_d    = assembled;
      end
    end
  end

  // A push into a full FIFO still succeeds when the head leaves on the same edge.
  always_comb begin
    pop    = word_out_valid && word_out_ready;
    accept = push_req && ((level_q < DepthLvl) || pop);
    drop   = push_req && !accept;

    wr_ptr_d = accept ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (accept && !pop) begin
      level_d = level_q + LvlW'(1);
    end else if (pop && !accept) begin
      level_d = level_q - LvlW'(1);
    end

    overflow_d = overflow_q;
    if (pixel_in_valid && sof_in) begin
      overflow_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_idx_q  <= '0;
      pack_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      pix_idx_q  <= pix_idx_d;
      pack_q     <= pack_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q]      <= push_word;
      last_mem_q[wr_ptr_q] <= push_last;
    end
  end

  // Storage is not reset, so the head is masked while the FIFO is empty.
  always_comb begin
    word_out_valid = (level_q != '0);
    word_out       = word_out_valid ? mem_q[rd_ptr_q] : '0;
    word_out_last  = word_out_valid ? last_mem_q[rd_ptr_q] : 1'b0;
    fifo_level     = level_q;
    almost_full    = (level_q >= AfLvl);
    overflow       = overflow_q;
  end

endmodule
